// File: rtl/irq_ctl_if.sv
// irq_ctl_if: handshake between the interrupt front-end and the CPU
// microcode sequencer.
//   sync     CPU -> ctl  first cycle of a new instruction
//   RDY      CPU -> ctl  CPU ready; 0 freezes the front-end FSM
//   I        CPU -> ctl  interrupt-disable flag
//   ack      CPU -> ctl  sequencer has started the vector fetch
//   take     ctl -> CPU  interrupt request
//   vec      ctl -> CPU  vector low byte (page is always $FF)
//   src_kind ctl -> CPU  00 IRQ, 01 NMI, 10 RST
//   src_irq  ctl -> CPU  IRQ channel index, valid when src_kind=00
// master = sequencer side, slave = irq_ctl side.
interface irq_ctl_if #(
  parameter int unsigned CHW = 3
);
  logic           sync;
  logic           RDY;
  logic           I;
  logic           ack;
  logic           take;
  logic [7:0]     vec;
  logic [1:0]     src_kind;
  logic [CHW-1:0] src_irq;

  modport master (
    output sync, RDY, I, ack,
    input  take, vec, src_kind, src_irq
  );

  modport slave (
    input  sync, RDY, I, ack,
    output take, vec, src_kind, src_irq
  );
endinterface

// File: rtl/irq_ctl.sv
// irq_ctl: prioritised interrupt front-end for the 65C02 core.
// Arbitrates RST > NMI > lowest-index IRQ channel at instruction
// boundaries and holds one locked request until the vector fetch is
// acknowledged.
// Ports:
//   clk        CPU clock
//   RST        synchronous active-high reset (also raises a reset request)
//   irq_in     IRQ lines, active-high
//   edge_mode  per channel: 1 rising-edge latched, 0 level
//   mask       per channel: 1 disabled
//   clr        write-1-clear of the edge latches
//   nmi        NMI, rising-edge sensitive
//   bus        sequencer handshake (irq_ctl_if.slave)
//   pending    registered per-channel pending status
module irq_ctl #(
  parameter int unsigned NUM_IRQ  = 8,
  parameter logic [7:0]  IRQ_BASE = 8'hE0,
  parameter int unsigned CHW      = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] edge_mode,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic [NUM_IRQ-1:0] clr,
  input  logic               nmi,
  irq_ctl_if.slave           bus,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_SVC} state_t;
  typedef enum logic [1:0] {
    KIND_IRQ = 2'b00,
    KIND_NMI = 2'b01,
    KIND_RST = 2'b10
  } kind_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_vec, w_vec_nxt;
  kind_t              r_kind, w_kind_nxt;
  logic [CHW-1:0]     r_irq, w_irq_nxt;

  logic               r_nmi_q, r_nmi_pend;
  logic [NUM_IRQ-1:0] r_irq_q, r_edge_lat, r_pending;

  logic [NUM_IRQ-1:0] w_elig_irq;
  logic               w_found, w_any;
  kind_t              w_arb_kind;
  logic [7:0]         w_arb_vec;
  logic [CHW-1:0]     w_arb_irq;
  logic               w_svc_nmi;
  logic [NUM_IRQ-1:0] w_svc_edge;

  assign w_elig_irq = r_pending & {NUM_IRQ{~bus.I}};

  // Priority arbitration: lowest eligible channel first, NMI overrides.
  always_comb begin
    w_found    = 1'b0;
    w_arb_kind = KIND_IRQ;
    w_arb_vec  = 8'hFE;
    w_arb_irq  = '0;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      if (w_elig_irq[k] && !w_found) begin
        w_found   = 1'b1;
        w_arb_irq = CHW'(k);
        w_arb_vec = (k == 0) ? 8'hFE : (IRQ_BASE + 8'(2 * k) - 8'd2);
      end
    end
    if (r_nmi_pend) begin
      w_arb_kind = KIND_NMI;
      w_arb_vec  = 8'hFA;
      w_arb_irq  = '0;
    end
    w_any = w_found | r_nmi_pend;
  end

  // Next-state / lock logic; RDY=0 holds everything.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_kind_nxt  = r_kind;
    w_irq_nxt   = r_irq;
    w_svc_nmi   = 1'b0;
    w_svc_edge  = '0;
    if (bus.RDY) begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.sync && w_any) begin
            w_state_nxt = S_PEND;
            w_vec_nxt   = w_arb_vec;
            w_kind_nxt  = w_arb_kind;
            w_irq_nxt   = w_arb_irq;
          end
        end
        S_PEND: begin
          if (bus.ack) begin
            w_state_nxt = S_SVC;
            if (r_kind == KIND_NMI) begin
              w_svc_nmi = 1'b1;
            end else if (r_kind == KIND_IRQ) begin
              // Level channels have nothing latched to clear.
              w_svc_edge[r_irq] = edge_mode[r_irq];
            end
          end
        end
        S_SVC: begin
          // Skip arbitration on this sync so the handler's I update lands.
          if (bus.sync) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= S_PEND;
      r_vec   <= 8'hFC;
      r_kind  <= KIND_RST;
      r_irq   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_kind  <= w_kind_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  // Edge detection and pending run regardless of RDY; a new edge beats
  // both clr and the service clear.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_nmi_q    <= 1'b0;
      r_nmi_pend <= 1'b0;
      r_irq_q    <= '0;
      r_edge_lat <= '0;
      r_pending  <= '0;
    end else begin
      r_nmi_q    <= nmi;
      r_nmi_pend <= (nmi & ~r_nmi_q) | (r_nmi_pend & ~w_svc_nmi);
      r_irq_q    <= irq_in;
      r_edge_lat <= (irq_in & ~r_irq_q & edge_mode)
                  | (r_edge_lat & ~clr & ~w_svc_edge);
      r_pending  <= ((edge_mode & r_edge_lat) | (~edge_mode & irq_in)) & ~mask;
    end
  end

  assign bus.take     = (r_state == S_PEND);
  assign bus.vec      = r_vec;
  assign bus.src_kind = r_kind;
  assign bus.src_irq  = r_irq;
  assign pending      = r_pending;

endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: self-checking bench for irq_ctl (NUM_IRQ=8, IRQ_BASE=E0).
// Expectations are queued as stimulus is driven and compared after the
// clock edge that produces them.
module tb_irq_ctl;

  logic       clk;
  logic       RST;
  logic [7:0] irq_in, edge_mode, mask, clr;
  logic       nmi;
  logic [7:0] pending;

  irq_ctl_if #(.CHW(3)) bus ();

  irq_ctl #(
    .NUM_IRQ  (8),
    .IRQ_BASE (8'hE0)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .irq_in    (irq_in),
    .edge_mode (edge_mode),
    .mask      (mask),
    .clr       (clr),
    .nmi       (nmi),
    .bus       (bus),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // chk: 0 = take only, 1 = take+vec+kind+channel, 2 = pending
  typedef struct {
    string       nm;
    int unsigned chk;
    logic        take;
    logic [7:0]  vec;
    logic [1:0]  kind;
    logic [2:0]  ch;
    logic [7:0]  pend;
  } exp_t;

  typedef struct {
    logic [7:0] irq;
    logic [7:0] msk;
    logic       iflag;
    logic [7:0] pend;
    logic       take;
    logic [7:0] vec;
    logic [2:0] ch;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push(string nm, int unsigned chk, logic t, logic [7:0] v,
                      logic [1:0] k, logic [2:0] c, logic [7:0] p);
    exp_t e;
    e.nm = nm; e.chk = chk; e.take = t; e.vec = v; e.kind = k; e.ch = c; e.pend = p;
    sb.push_back(e);
  endtask

  task automatic exp_take(string nm, logic t);
    push(nm, 0, t, 8'h00, 2'b00, 3'd0, 8'h00);
  endtask

  task automatic exp_lock(string nm, logic t, logic [7:0] v, logic [1:0] k, logic [2:0] c);
    push(nm, 1, t, v, k, c, 8'h00);
  endtask

  task automatic exp_pend(string nm, logic [7:0] p);
    push(nm, 2, 1'b0, 8'h00, 2'b00, 3'd0, p);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (e.chk == 2) begin
        if (pending !== e.pend) begin
          n_fail++;
          $display("FAIL %s: pending=%h required %h", e.nm, pending, e.pend);
        end
      end else if (e.chk == 1) begin
        if (bus.take !== e.take || bus.vec !== e.vec ||
            bus.src_kind !== e.kind || bus.src_irq !== e.ch) begin
          n_fail++;
          $display("FAIL %s: take=%b vec=%h kind=%b ch=%0d required take=%b vec=%h kind=%b ch=%0d",
                   e.nm, bus.take, bus.vec, bus.src_kind, bus.src_irq,
                   e.take, e.vec, e.kind, e.ch);
        end
      end else begin
        if (bus.take !== e.take) begin
          n_fail++;
          $display("FAIL %s: take=%b required %b", e.nm, bus.take, e.take);
        end
      end
    end
  endtask

  task automatic sync_cycle(string nm, logic t);
    bus.sync = 1'b1;
    exp_take(nm, t);
    tick();
    bus.sync = 1'b0;
  endtask

  task automatic sync_lock(string nm, logic [7:0] v, logic [1:0] k, logic [2:0] c);
    bus.sync = 1'b1;
    exp_lock(nm, 1'b1, v, k, c);
    tick();
    bus.sync = 1'b0;
  endtask

  task automatic do_ack(string nm);
    bus.ack = 1'b1;
    exp_take(nm, 1'b0);
    tick();
    bus.ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; irq_in = '0; edge_mode = '0; mask = '0; clr = '0; nmi = 1'b0;
    bus.sync = 1'b0; bus.RDY = 1'b1; bus.I = 1'b0; bus.ack = 1'b0;

    //           irq    mask   I     pend   take  vec    ch
    tbl[0] = '{8'h06, 8'h00, 1'b0, 8'h06, 1'b1, 8'hE0, 3'd1};
    tbl[1] = '{8'h80, 8'h00, 1'b0, 8'h80, 1'b1, 8'hEC, 3'd7};
    tbl[2] = '{8'h81, 8'h00, 1'b0, 8'h81, 1'b1, 8'hFE, 3'd0};
    tbl[3] = '{8'hF0, 8'h10, 1'b0, 8'hE0, 1'b1, 8'hE8, 3'd5};
    tbl[4] = '{8'h01, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 3'd0};
    tbl[5] = '{8'h08, 8'h08, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0};
    tbl[6] = '{8'h40, 8'h00, 1'b0, 8'h40, 1'b1, 8'hEA, 3'd6};

    // Reset request
    for (int i = 0; i < 3; i++) begin
      exp_lock("rst_hold", 1'b1, 8'hFC, 2'b10, 3'd0);
      exp_pend("rst_pend", 8'h00);
      tick();
    end
    RST = 1'b0;
    exp_lock("rst_release", 1'b1, 8'hFC, 2'b10, 3'd0);
    tick();
    bus.ack = 1'b1;
    exp_lock("rst_ack", 1'b0, 8'hFC, 2'b10, 3'd0);
    tick();
    bus.ack = 1'b0;
    sync_cycle("rst_svc_sync", 1'b0);
    sync_cycle("rst_idle_sync", 1'b0);

    // NMI ignores I and is edge-only
    bus.I = 1'b1; nmi = 1'b1;
    exp_take("nmi_wait", 1'b0);
    tick();
    sync_lock("nmi_lock", 8'hFA, 2'b01, 3'd0);
    do_ack("nmi_ack");
    for (int i = 0; i < 4; i++) sync_cycle("nmi_no_retake", 1'b0);
    nmi = 1'b0; bus.I = 1'b0;
    tick();

    // Level channels, SVC skips one sync
    irq_in = 8'h06;
    exp_pend("lvl_pend", 8'h06);
    tick();
    sync_lock("lvl_ch1", 8'hE0, 2'b00, 3'd1);
    bus.ack = 1'b1; irq_in = 8'h04;
    exp_take("lvl_ack", 1'b0);
    tick();
    bus.ack = 1'b0;
    sync_cycle("lvl_svc_sync", 1'b0);
    sync_lock("lvl_ch2", 8'hE2, 2'b00, 3'd2);
    do_ack("lvl_ack2");
    irq_in = 8'h00;
    sync_cycle("lvl_idle", 1'b0);

    // Table: priority, vectors, masking, I gating
    for (int i = 0; i < 7; i++) begin
      irq_in = tbl[i].irq; mask = tbl[i].msk; bus.I = tbl[i].iflag;
      exp_pend($sformatf("tbl%0d_pend", i), tbl[i].pend);
      tick();
      bus.sync = 1'b1;
      if (tbl[i].take) exp_lock($sformatf("tbl%0d_lock", i), 1'b1, tbl[i].vec, 2'b00, tbl[i].ch);
      else             exp_take($sformatf("tbl%0d_none", i), 1'b0);
      tick();
      bus.sync = 1'b0;
      if (tbl[i].take) begin
        do_ack($sformatf("tbl%0d_ack", i));
        irq_in = 8'h00;
        sync_cycle($sformatf("tbl%0d_svc", i), 1'b0);
      end else begin
        irq_in = 8'h00;
        tick();
      end
      mask = 8'h00; bus.I = 1'b0;
      tick();
    end

    // I=1 blocks a level IRQ until cleared
    irq_in = 8'h01; bus.I = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) sync_cycle("ig_blocked", 1'b0);
    bus.I = 1'b0;
    sync_lock("ig_lock", 8'hFE, 2'b00, 3'd0);
    do_ack("ig_ack");
    irq_in = 8'h00;
    sync_cycle("ig_svc", 1'b0);
    mask = 8'h01; irq_in = 8'h01;
    exp_pend("mk_pend", 8'h00);
    tick();
    for (int i = 0; i < 3; i++) sync_cycle("mk_never", 1'b0);
    irq_in = 8'h00; mask = 8'h00;
    tick();

    // Edge channel 3: latch, clear, set-wins, service clear
    edge_mode = 8'h08; irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    exp_pend("edge_pend", 8'h08);
    tick();
    for (int i = 0; i < 2; i++) begin
      exp_pend("edge_hold", 8'h08);
      tick();
    end
    clr = 8'h08;
    tick();
    clr = 8'h00;
    exp_pend("edge_clr", 8'h00);
    tick();
    sync_cycle("edge_clr_no_take", 1'b0);
    irq_in = 8'h08; clr = 8'h08;
    tick();
    irq_in = 8'h00; clr = 8'h00;
    exp_pend("edge_setwins", 8'h08);
    tick();
    sync_lock("edge_lock", 8'hE4, 2'b00, 3'd3);
    do_ack("edge_ack");
    exp_pend("edge_cleared", 8'h00);
    sync_cycle("edge_svc", 1'b0);
    sync_cycle("edge_no_retake", 1'b0);
    edge_mode = 8'h00;
    tick();

    // RDY=0 freezes FSM across a sync and an ack; latches still run
    bus.RDY = 1'b0; nmi = 1'b1; irq_in = 8'h01;
    exp_lock("frz_start", 1'b0, 8'hE4, 2'b00, 3'd3);
    tick();
    nmi = 1'b0; bus.sync = 1'b1;
    exp_lock("frz_sync", 1'b0, 8'hE4, 2'b00, 3'd3);
    exp_pend("frz_pend", 8'h01);
    tick();
    bus.sync = 1'b0; bus.ack = 1'b1;
    exp_lock("frz_ack", 1'b0, 8'hE4, 2'b00, 3'd3);
    tick();
    bus.ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_lock("frz_hold", 1'b0, 8'hE4, 2'b00, 3'd3);
      tick();
    end
    bus.RDY = 1'b1;
    sync_lock("frz_nmi_first", 8'hFA, 2'b01, 3'd0);
    bus.RDY = 1'b0; bus.ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_lock("frz_take_hold", 1'b1, 8'hFA, 2'b01, 3'd0);
      tick();
    end
    bus.RDY = 1'b1;
    exp_take("frz_ack_take", 1'b0);
    tick();
    bus.ack = 1'b0;
    sync_cycle("frz_svc", 1'b0);
    sync_lock("frz_irq_second", 8'hFE, 2'b00, 3'd0);
    do_ack("frz_irq_ack");
    irq_in = 8'h00;
    sync_cycle("frz_idle", 1'b0);

    // NMI edge in the ack cycle survives the service clear
    nmi = 1'b1;
    tick();
    nmi = 1'b0;
    sync_lock("nre_lock", 8'hFA, 2'b01, 3'd0);
    bus.ack = 1'b1; nmi = 1'b1;
    exp_take("nre_ack", 1'b0);
    tick();
    bus.ack = 1'b0; nmi = 1'b0;
    sync_cycle("nre_svc", 1'b0);
    sync_lock("nre_retake", 8'hFA, 2'b01, 3'd0);
    do_ack("nre_ack2");
    sync_cycle("nre_idle", 1'b0);

    // RST while an IRQ is locked overrides the request
    irq_in = 8'h01;
    tick();
    sync_lock("mid_lock", 8'hFE, 2'b00, 3'd0);
    RST = 1'b1;
    exp_lock("mid_rst", 1'b1, 8'hFC, 2'b10, 3'd0);
    exp_pend("mid_rst_pend", 8'h00);
    tick();
    RST = 1'b0; irq_in = 8'h00;
    exp_lock("mid_rst_hold", 1'b1, 8'hFC, 2'b10, 3'd0);
    tick();
    do_ack("mid_ack");
    sync_cycle("mid_idle", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
